// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the instruction-decode stage:
//   - width defaults (PC, data, register count, register index width)
//   - instruction field bit positions
//   - supported opcodes and ALU operation classes
//   - ctrl_t and decode_ctrl(), which map an opcode to its ID/EX control bits
// -----------------------------------------------------------------------------
package decode_pkg;

  localparam int PC_W_DEF   = 7;
  localparam int DATA_W_DEF = 32;
  localparam int REG_N_DEF  = 32;
  localparam int REG_AW     = 5;

  // Instruction field positions
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int IMM_MSB   = 15;

  // Supported opcodes
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  // ALU operation classes handed to EX
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_RTYPE = 2'd2;

  // valid marks ops that have an EX-stage effect; everything else is a bubble
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [1:0]        alu_op;
    logic [REG_AW-1:0] dest;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0]        op,
                                        input logic [REG_AW-1:0] rt,
                                        input logic [REG_AW-1:0] rd);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R: begin
        c.valid     = 1'b1;
        c.reg_write = 1'b1;
        c.dest      = rd;
        c.alu_op    = ALU_RTYPE;
      end
      OP_ADDI: begin
        c.valid     = 1'b1;
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.dest      = rt;
        c.alu_op    = ALU_ADD;
      end
      OP_LW: begin
        c.valid     = 1'b1;
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src   = 1'b1;
        c.dest      = rt;
        c.alu_op    = ALU_ADD;
      end
      OP_SW: begin
        c.valid     = 1'b1;
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      default: c = '0;
    endcase
    // r0 is hardwired, so a write aimed at it is dropped here
    c.reg_write = c.reg_write & (c.dest != {REG_AW{1'b0}});
    return c;
  endfunction

endpackage

// File: rtl/decode_if.sv
// -----------------------------------------------------------------------------
// decode_if
// Bundle of every decode-stage signal except clk/rst.
//   Upstream/side inputs : enbl, pc_in, instr, wb_we/wb_addr/wb_data,
//                          mem_rd/mem_rw
//   Fetch feedback       : stall, br_take, br_target (combinational)
//   ID/EX register       : ex_* (registered)
// Modports: master = environment driving the stage, slave = decode_stage.
// -----------------------------------------------------------------------------
interface decode_if
  import decode_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              enbl;
  logic [PC_W-1:0]   pc_in;
  logic [DATA_W-1:0] instr;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_rw;

  logic              stall;
  logic              br_take;
  logic [PC_W-1:0]   br_target;

  logic [PC_W-1:0]   ex_pc;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_dest;
  logic [5:0]        ex_funct;
  logic [1:0]        ex_alu_op;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_alu_src;

  modport master (
    output enbl, pc_in, instr, wb_we, wb_addr, wb_data, mem_rd, mem_rw,
    input  stall, br_take, br_target,
    input  ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest,
    input  ex_funct, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write,
    input  ex_alu_src
  );

  modport slave (
    input  enbl, pc_in, instr, wb_we, wb_addr, wb_data, mem_rd, mem_rw,
    output stall, br_take, br_target,
    output ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest,
    output ex_funct, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write,
    output ex_alu_src
  );
endinterface

// File: rtl/decode_regfile.sv
// -----------------------------------------------------------------------------
// decode_regfile
// REG_N x DATA_W register file, two combinational read ports, one write port.
// r0 always reads zero and is never written. Cleared by asynchronous reset.
// Optional feature (macro DECODE_BYPASS_EN): a read of the register being
// written this cycle returns the write data directly.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   we_i, waddr_i, wdata_i  write port (write on rising edge)
//   raddr_a_i / rdata_a_o   read port A
//   raddr_b_i / rdata_b_o   read port B
// -----------------------------------------------------------------------------
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_N  = REG_N_DEF,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [REG_N];

  // Register storage: cleared on reset, written on rising edge except r0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_i && (waddr_i != {AW{1'b0}})) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports with r0 forced to zero and optional write-through bypass
  always_comb begin
    rdata_a_o = {DATA_W{1'b0}};
    rdata_b_o = {DATA_W{1'b0}};
    if (raddr_a_i != {AW{1'b0}}) begin
      rdata_a_o = regs_q[raddr_a_i];
    end else begin
      rdata_a_o = {DATA_W{1'b0}};
    end
    if (raddr_b_i != {AW{1'b0}}) begin
      rdata_b_o = regs_q[raddr_b_i];
    end else begin
      rdata_b_o = {DATA_W{1'b0}};
    end
`ifdef DECODE_BYPASS_EN
    if (we_i && (waddr_i != {AW{1'b0}}) && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end else begin
      rdata_a_o = rdata_a_o;
    end
    if (we_i && (waddr_i != {AW{1'b0}}) && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end else begin
      rdata_b_o = rdata_b_o;
    end
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Instruction-decode stage of the 5-stage pipeline.
//   - decodes R/ADDI/LW/SW into the ID/EX register (one cycle latency);
//     BEQ, J and unknown opcodes enter EX as bubbles
//   - resolves BEQ/J here and returns br_take/br_target to fetch
//   - detects load-use and branch-operand hazards and raises stall
//   - squashes the instruction following a taken branch/jump
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        decode_if.slave (inputs from fetch/WB/MEM, fetch feedback,
//              ID/EX outputs)
// Optional feature macro: DECODE_BYPASS_EN. When defined the register file
// forwards same-cycle write-back data; when undefined a write-back to a used
// source register stalls decode for one cycle instead.
// -----------------------------------------------------------------------------
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_N  = REG_N_DEF
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  // Instruction fields
  logic [5:0]        op_s;
  logic [REG_AW-1:0] rs_s;
  logic [REG_AW-1:0] rt_s;
  logic [REG_AW-1:0] rd_s;
  logic [15:0]       imm_s;
  ctrl_t             ctrl_s;

  assign op_s   = bus.instr[OP_MSB:OP_LSB];
  assign rs_s   = bus.instr[RS_MSB:RS_LSB];
  assign rt_s   = bus.instr[RT_MSB:RT_LSB];
  assign rd_s   = bus.instr[RD_MSB:RD_LSB];
  assign imm_s  = bus.instr[IMM_MSB:0];
  assign ctrl_s = decode_ctrl(op_s, rt_s, rd_s);

  // Register file
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;

  decode_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (bus.enbl & bus.wb_we),
    .waddr_i   (bus.wb_addr),
    .wdata_i   (bus.wb_data),
    .raddr_a_i (rs_s),
    .raddr_b_i (rt_s),
    .rdata_a_o (rs_data_s),
    .rdata_b_o (rt_data_s)
  );

  // ID/EX register and squash flag
  logic [PC_W-1:0]   ex_pc_q,        ex_pc_d;
  logic [DATA_W-1:0] ex_rs_data_q,   ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q,   ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
  logic [REG_AW-1:0] ex_rs_q,        ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,        ex_rt_d;
  logic [REG_AW-1:0] ex_dest_q,      ex_dest_d;
  logic [5:0]        ex_funct_q,     ex_funct_d;
  logic [1:0]        ex_alu_op_q,    ex_alu_op_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q,  ex_mem_read_d;
  logic              ex_mem_write_q, ex_mem_write_d;
  logic              ex_alu_src_q,   ex_alu_src_d;
  logic              squash_q;

  // Hazard and branch signals
  logic              is_beq_s;
  logic              is_j_s;
  logic              use_rs_s;
  logic              use_rt_s;
  logic              load_use_s;
  logic              br_haz_s;
  logic              wb_haz_s;
  logic              stall_s;
  logic              br_take_s;
  logic [PC_W-1:0]   br_target_s;

  assign is_beq_s = (op_s == OP_BEQ);
  assign is_j_s   = (op_s == OP_J);
  // rs is read by every op except J; rt only by R, SW and BEQ
  assign use_rs_s = ctrl_s.valid | is_beq_s;
  assign use_rt_s = (op_s == OP_R) | (op_s == OP_SW) | is_beq_s;

  // Hazard detection, stall and branch resolution
  always_comb begin
    load_use_s = ex_mem_read_q && (ex_dest_q != {REG_AW{1'b0}}) &&
                 ((ex_dest_q == rs_s) || (use_rt_s && (ex_dest_q == rt_s)));

    // ex_reg_write_q already implies ex_dest_q != 0
    br_haz_s   = is_beq_s &&
                 ((ex_reg_write_q && ((ex_dest_q == rs_s) || (ex_dest_q == rt_s))) ||
                  (bus.mem_rw && (bus.mem_rd != {REG_AW{1'b0}}) &&
                   ((bus.mem_rd == rs_s) || (bus.mem_rd == rt_s))));

`ifdef DECODE_BYPASS_EN
    wb_haz_s   = 1'b0;
`else
    // Without forwarding, wait one cycle so the register file holds the value
    wb_haz_s   = bus.wb_we && (bus.wb_addr != {REG_AW{1'b0}}) &&
                 ((use_rs_s && (bus.wb_addr == rs_s)) ||
                  (use_rt_s && (bus.wb_addr == rt_s)));
`endif

    // A squashed slot gets no hazard or branch evaluation at all
    if (rst || squash_q) begin
      stall_s   = 1'b0;
      br_take_s = 1'b0;
    end else begin
      stall_s   = load_use_s | br_haz_s | wb_haz_s;
      br_take_s = !stall_s &&
                  (is_j_s || (is_beq_s && (rs_data_s == rt_data_s)));
    end

    if (is_j_s) begin
      br_target_s = bus.instr[PC_W-1:0];
    end else begin
      br_target_s = bus.pc_in + {{(PC_W-1){1'b0}}, 1'b1} + bus.instr[PC_W-1:0];
    end
  end

  // Next ID/EX contents: decoded op or an all-zero bubble
  always_comb begin
    ex_pc_d        = {PC_W{1'b0}};
    ex_rs_data_d   = {DATA_W{1'b0}};
    ex_rt_data_d   = {DATA_W{1'b0}};
    ex_imm_d       = {DATA_W{1'b0}};
    ex_rs_d        = {REG_AW{1'b0}};
    ex_rt_d        = {REG_AW{1'b0}};
    ex_dest_d      = {REG_AW{1'b0}};
    ex_funct_d     = 6'd0;
    ex_alu_op_d    = 2'd0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    ex_mem_write_d = 1'b0;
    ex_alu_src_d   = 1'b0;
    if (ctrl_s.valid && !squash_q && !stall_s) begin
      ex_pc_d        = bus.pc_in;
      ex_rs_data_d   = rs_data_s;
      ex_rt_data_d   = rt_data_s;
      ex_imm_d       = {{(DATA_W-16){imm_s[15]}}, imm_s};
      ex_rs_d        = rs_s;
      ex_rt_d        = rt_s;
      ex_dest_d      = ctrl_s.dest;
      ex_funct_d     = (op_s == OP_R) ? bus.instr[FUNCT_MSB:0] : 6'd0;
      ex_alu_op_d    = ctrl_s.alu_op;
      ex_reg_write_d = ctrl_s.reg_write;
      ex_mem_read_d  = ctrl_s.mem_read;
      ex_mem_write_d = ctrl_s.mem_write;
      ex_alu_src_d   = ctrl_s.alu_src;
    end else begin
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      ex_alu_src_d   = 1'b0;
    end
  end

  // ID/EX register and squash flag; enbl=0 freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc_q        <= {PC_W{1'b0}};
      ex_rs_data_q   <= {DATA_W{1'b0}};
      ex_rt_data_q   <= {DATA_W{1'b0}};
      ex_imm_q       <= {DATA_W{1'b0}};
      ex_rs_q        <= {REG_AW{1'b0}};
      ex_rt_q        <= {REG_AW{1'b0}};
      ex_dest_q      <= {REG_AW{1'b0}};
      ex_funct_q     <= 6'd0;
      ex_alu_op_q    <= 2'd0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_alu_src_q   <= 1'b0;
      squash_q       <= 1'b0;
    end else if (bus.enbl) begin
      ex_pc_q        <= ex_pc_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_dest_q      <= ex_dest_d;
      ex_funct_q     <= ex_funct_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_alu_src_q   <= ex_alu_src_d;
      squash_q       <= br_take_s;
    end
  end

  assign bus.stall        = stall_s;
  assign bus.br_take      = br_take_s;
  assign bus.br_target    = br_target_s;
  assign bus.ex_pc        = ex_pc_q;
  assign bus.ex_rs_data   = ex_rs_data_q;
  assign bus.ex_rt_data   = ex_rt_data_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_rs        = ex_rs_q;
  assign bus.ex_rt        = ex_rt_q;
  assign bus.ex_dest      = ex_dest_q;
  assign bus.ex_funct     = ex_funct_q;
  assign bus.ex_alu_op    = ex_alu_op_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.ex_mem_read  = ex_mem_read_q;
  assign bus.ex_mem_write = ex_mem_write_q;
  assign bus.ex_alu_src   = ex_alu_src_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage pipeline. Sits directly downstream of the fetch stage.
- Consumes the fetched instruction word and its PC.
- Reads the 32x32 register file and accepts write-back from WB.
- Resolves BEQ/J in decode, returning the redirect to fetch.
- Detects load-use and branch-operand hazards, stalls fetch, and drives the ID/EX pipeline register.

Parameters:
- PC_W, 7, PC width; word-addressed, wraps modulo 2^PC_W.
- DATA_W, 32, instruction and register data width.
- REG_N, 32, register count; index width is clog2(REG_N) = 5.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- enbl  in  1  global pipeline advance enable; 0 freezes every register in the block.
- pc_in  in  PC_W  PC of instr.
- instr  in  DATA_W  fetched instruction (DR from fetch).
- wb_we  in  1  write-back enable.
- wb_addr  in  5  write-back register index.
- wb_data  in  DATA_W  write-back data.
- mem_rd  in  5  destination register of the instruction in EX/MEM.
- mem_rw  in  1  that instruction writes a register.
- stall  out  1  hold fetch PC and instr (combinational).
- br_take  out  1  redirect fetch (combinational).
- br_target  out  PC_W  redirect PC (combinational).
- ex_pc  out  PC_W  ID/EX register: PC.
- ex_rs_data, ex_rt_data  out  DATA_W  ID/EX register: operand data.
- ex_imm  out  DATA_W  ID/EX register: sign-extended imm[15:0].
- ex_rs, ex_rt, ex_dest  out  5  ID/EX register: source and destination indices.
- ex_funct  out  6  ID/EX register: R-type funct field.
- ex_alu_op  out  2  ID/EX register: ALU operation class.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1  ID/EX register: control bits.

Behaviour:
- Instruction format:
  - op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0], imm = [15:0].
  - Supported ops: R 0x00, ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02.
  - Any other op decodes as a bubble.
- Control by op:
  - R: reg_write=1, dest=rd, alu_op=2.
  - ADDI: reg_write=1, alu_src=1, dest=rt, alu_op=0.
  - LW: reg_write=1, mem_read=1, alu_src=1, dest=rt, alu_op=0.
  - SW: mem_write=1, alu_src=1, alu_op=0.
  - BEQ and J: no EX-stage effect; emitted as bubble.
  - Writes with dest=0 force reg_write=0.
- Register file:
  - Written on rising edge when wb_we=1 and wb_addr!=0.
  - r0 always reads 0.
  - Reads are combinational.
- Load-use hazard: ex_mem_read=1, ex_dest!=0, and ex_dest matches rs, or matches rt for R/BEQ/SW.
- Branch-operand hazard: op=BEQ, and either
  - (ex_reg_write=1 and ex_dest matches rs or rt), or
  - (mem_rw=1 and mem_rd!=0 and matches rs or rt).
- stall = load-use hazard OR branch-operand hazard (OR bypass hazard, see Optional Feature).
  - While stall=1: ID/EX loads a bubble (all control bits 0, indices 0).
  - br_take is forced to 0.
- Branch resolution:
  - BEQ taken when rs_data == rt_data; br_target = pc_in + 1 + imm[PC_W-1:0], modulo 2^PC_W.
  - J always taken; br_target = instr[PC_W-1:0].
- Squash:
  - When br_take=1 and enbl=1, a squash flag is set for one cycle.
  - The next instruction is decoded as a bubble, with no hazard or branch evaluation.
- Latency: one cycle from instr to ex_* outputs.
- Priority: rst > enbl=0 (hold everything) > squash > stall > normal decode.
- Reset (asynchronous):
  - All ex_* outputs 0; squash flag 0.
  - Register file cleared to 0.
  - stall and br_take are 0 while rst=1.
- Write-back to a register in the same cycle it is read: governed by the optional feature below.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined:
  - Reads bypass the register file.
  - If wb_we=1 and wb_addr equals the read index (and is non-zero), the read returns wb_data in the same cycle.
- Undefined:
  - No bypass.
  - An extra hazard term asserts stall when wb_we=1, wb_addr!=0, and wb_addr matches a used source.
  - The instruction re-decodes the next cycle with the written value.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams (OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J);
  - alu_op codes;
  - field bit positions;
  - PC_W/DATA_W defaults.
- One natural sub-module: decode_regfile (2 read, 1 write, r0 hardwired, optional bypass).
- Hazard logic and the ID/EX register stay in decode_stage.

Test Plan:
- Decode ADDI 0x20010005 at pc_in=3 after reset → next cycle ex_reg_write=1, ex_alu_src=1, ex_dest=1, ex_imm=5, ex_pc=3.
- Load-use: LW 0x8C220000, then ADD 0x00411820 → stall=1 for exactly one cycle; ID/EX holds a bubble; ADD issues the following cycle with ex_rs=2.
- BEQ 0x10210003 at pc_in=10, r1=r1, no hazards → br_take=1, br_target=14; the next instruction is squashed (ex_reg_write=0).
- Wrap-around: BEQ with imm=5 at pc_in=126, taken → br_target=4; J with instr[6:0]=0x55 → br_target=85.
- Bypass: wb_we=1, wb_addr=4, wb_data=0xDEADBEEF while decoding R-type with rs=4:
  - with DECODE_BYPASS_EN → ex_rs_data=0xDEADBEEF next cycle, stall=0;
  - without → stall=1 for one cycle, then 0xDEADBEEF.
- rst asserted mid-stall → all ex_* outputs 0 immediately, stall=0, and a read of r1 returns 0 after release.
